// File: rtl/div_pkg.sv
// Shared definitions for the divider result BCD converter: default widths, FSM encoding
// and the double-dabble per-nibble correction.
package div_pkg;

  localparam int unsigned DIV_WIDTH  = 9;
  localparam int unsigned BCD_DIGITS = 3;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StConv = 2'b01,
    StHold = 2'b10
  } div_state_e;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/dd_shift_unit.sv
// One sequential double-dabble lane: a {bcd, bin} register pair that is loaded with a binary
// operand and then corrected and shifted one bit per iteration.
module dd_shift_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_WIDTH,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                iter_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic [4*DIGITS-1:0] bcd_next_o
);

  logic [4*DIGITS-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [WIDTH-1:0]          bin_q, bin_d;
  logic [4*DIGITS+WIDTH-1:0] shifted;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  // The corrected accumulator never carries out of the top digit for valid widths.
  assign shifted    = {bcd_adj, bin_q} << 1;
  assign bcd_next_o = shifted[4*DIGITS+WIDTH-1:WIDTH];

  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    if (load_i) begin
      bcd_d = '0;
      bin_d = bin_i;
    end else if (iter_i) begin
      bcd_d = bcd_next_o;
      bin_d = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q <= '0;
      bin_q <= '0;
    end else begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
    end
  end

endmodule

// File: rtl/div_result_bcd.sv
// Captures divider quotient/remainder on the rising edge of ready, converts both to packed BCD
// and offers the result over a valid/ack handshake. DIV_BCD_SIGNED_EN adds sign/magnitude mode.
module div_result_bcd
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_WIDTH,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_ready,
  input  logic [WIDTH-1:0]    Qbus,
  input  logic [WIDTH-1:0]    Rbus,
  input  logic                out_ack,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
`ifdef DIV_BCD_SIGNED_EN
  ,
  output logic                q_neg,
  output logic                r_neg
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e          state_q, state_d;
  logic                ready_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                cap, last;
  logic                load, iter, finish, drop;
  logic [WIDTH-1:0]    q_mag, r_mag;
  logic [4*DIGITS-1:0] q_next, r_next;
  logic [4*DIGITS-1:0] q_bcd_q, r_bcd_q;
  logic                overrun_q;

  // ready_q resets high so an idle divider at reset does not look like a fresh result.
  assign cap  = div_ready & ~ready_q;
  assign last = (cnt_q == CntW'(WIDTH - 1));

`ifdef DIV_BCD_SIGNED_EN
  logic q_sign_q, r_sign_q;
  logic q_neg_q, r_neg_q;

  assign q_mag = Qbus[WIDTH-1] ? (~Qbus + WIDTH'(1)) : Qbus;
  assign r_mag = Rbus[WIDTH-1] ? (~Rbus + WIDTH'(1)) : Rbus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      if (load) begin
        q_sign_q <= Qbus[WIDTH-1];
        r_sign_q <= Rbus[WIDTH-1];
      end
      if (finish) begin
        q_neg_q <= q_sign_q;
        r_neg_q <= r_sign_q;
      end
    end
  end

  assign q_neg = q_neg_q;
  assign r_neg = r_neg_q;
`else
  assign q_mag = Qbus;
  assign r_mag = Rbus;
`endif

  // State register and per-cycle datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      cnt_q     <= '0;
      q_bcd_q   <= '0;
      r_bcd_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= div_ready;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_q | drop;
      if (finish) begin
        q_bcd_q <= q_next;
        r_bcd_q <= r_next;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cap) state_d = StConv;
      StConv:  if (last) state_d = StHold;
      StHold:  if (out_ack) state_d = cap ? StConv : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control decode; an ack coinciding with a new edge in HOLD restarts conversion directly.
  always_comb begin
    load   = 1'b0;
    iter   = 1'b0;
    finish = 1'b0;
    drop   = 1'b0;
    unique case (state_q)
      StIdle: load = cap;
      StConv: begin
        iter   = 1'b1;
        finish = last;
        drop   = cap;
      end
      StHold: begin
        load = cap & out_ack;
        drop = cap & ~out_ack;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (iter) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  dd_shift_unit #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_q_unit (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (load),
    .iter_i     (iter),
    .bin_i      (q_mag),
    .bcd_next_o (q_next)
  );

  dd_shift_unit #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_r_unit (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (load),
    .iter_i     (iter),
    .bin_i      (r_mag),
    .bcd_next_o (r_next)
  );

  assign q_bcd     = q_bcd_q;
  assign r_bcd     = r_bcd_q;
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q == StConv);
  assign overrun   = overrun_q;

endmodule
